// File: rtl/fp16_tpu_pkg.sv
// Shared types and constants for the FP16 TPU MAC lane: sequencer state
// encoding, common FP16 constants and the default MAC pipeline latency.
package fp16_tpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } mac_seq_state_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    localparam int DEFAULT_MAC_LATENCY = 1;

endpackage

// File: rtl/fp16_approx_mac_unit.sv
// Single FP16 multiply-accumulate lane with truncating arithmetic.
// Denormals flush to zero and overflow saturates to infinity.
module fp16_approx_mac_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] acc_out
);

    function automatic logic [15:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
        logic        s;
        logic [21:0] p;
        logic [9:0]  m;
        logic [15:0] r;
        int          e;
        s = x[15] ^ y[15];
        p = {1'b1, x[9:0]} * {1'b1, y[9:0]};
        e = int'(x[14:10]) + int'(y[14:10]) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        if (x[14:10] == 5'd0 || y[14:10] == 5'd0 || e <= 0)
            r = 16'h0000;
        else if (e >= 31)
            r = {s, 5'h1f, 10'h000};
        else
            r = {s, 5'(e), m};
        return r;
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] p, input logic [15:0] q);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        logic [13:0] mx;
        logic [13:0] my;
        logic [13:0] d;
        logic [14:0] s;
        int          e;
        int          sh;
        // x always carries the larger magnitude, so it also sets the sign
        if (p[14:0] >= q[14:0]) begin
            x = p;
            y = q;
        end else begin
            x = q;
            y = p;
        end
        mx = {1'b1, x[9:0], 3'b000};
        my = {1'b1, y[9:0], 3'b000};
        sh = int'(x[14:10]) - int'(y[14:10]);
        my = (sh > 13) ? 14'd0 : (my >> sh);
        e  = int'(x[14:10]);
        s  = '0;
        d  = '0;
        if (y[14:10] == 5'd0) begin
            r = x;
        end else if (x[15] == y[15]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[14]) begin
                d = s[14:1];
                e = e + 1;
            end else begin
                d = s[13:0];
            end
            r = (e >= 31) ? {x[15], 5'h1f, 10'h000} : {x[15], 5'(e), d[12:3]};
        end else begin
            d = mx - my;
            for (int i = 0; i < 13; i++) begin
                if (!d[13]) begin
                    d = d << 1;
                    e = e - 1;
                end
            end
            r = (d == 14'd0 || e <= 0) ? 16'h0000 : {x[15], 5'(e), d[12:3]};
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            acc_out <= 16'h0000;
        else if (enable)
            acc_out <= fp16_add(acc_out, fp16_mul(a, b));
    end

endmodule

// File: rtl/fp16_mac_dot_sequencer.sv
// Drives one fp16_approx_mac_unit through a dot-product job: clear, stream
// N operand pairs, wait out the MAC latency, present the FP16 result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; lane untouched
// S_CLEAR | one cycle with mac_clr high; empties the accumulator
// S_RUN   | op_ready high; each handshake feeds one pair to the MAC
// S_DRAIN | MAC_LATENCY+1 cycles for the last product to land
// S_DONE  | res_valid high with res_data held until res_ready
module fp16_mac_dot_sequencer
    import fp16_tpu_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int MAC_LATENCY = DEFAULT_MAC_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    input  logic [15:0]      acc_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             busy
);

    localparam int DRAIN_W = $clog2(MAC_LATENCY + 2);

    mac_seq_state_t   state;
    logic [LEN_W-1:0] rem;
    logic [DRAIN_W-1:0] drain_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rem       <= '0;
            drain_cnt <= '0;
            op_ready  <= 1'b0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            mac_a     <= 16'h0000;
            mac_b     <= 16'h0000;
            res_valid <= 1'b0;
            res_data  <= 16'h0000;
            busy      <= 1'b0;
        end else begin
            mac_clr <= 1'b0;
            mac_en  <= 1'b0;
            if (abort && state != S_IDLE) begin
                // Abandon the job and scrub the lane's partial sum
                state     <= S_IDLE;
                mac_clr   <= 1'b1;
                op_ready  <= 1'b0;
                res_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            rem     <= len;
                            state   <= S_CLEAR;
                            mac_clr <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        if (rem != '0) begin
                            state    <= S_RUN;
                            op_ready <= 1'b1;
                        end else begin
                            state     <= S_DONE;
                            res_data  <= FP16_ZERO;
                            res_valid <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (op_valid && op_ready) begin
                            mac_a  <= op_a;
                            mac_b  <= op_b;
                            mac_en <= 1'b1;
                            if (rem != '0)
                                rem <= rem - LEN_W'(1);
                            if (rem == LEN_W'(1)) begin
                                state     <= S_DRAIN;
                                op_ready  <= 1'b0;
                                drain_cnt <= DRAIN_W'(MAC_LATENCY);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == '0) begin
                            res_data  <= acc_in;
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        op_ready  <= 1'b0;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp16_mac_dot_sequencer.sv
// Bench for the dot-product sequencer driving a real MAC lane: a table of
// whole jobs plus hand-written abort, reset and ignored-start sequences.
module tb_fp16_mac_dot_sequencer;
    import fp16_tpu_pkg::*;

    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic             mac_clr;
    logic             mac_en;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic [15:0]      acc_in;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fp16_mac_dot_sequencer #(.LEN_W(LEN_W), .MAC_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .acc_in(acc_in), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy)
    );

    fp16_approx_mac_unit mac (
        .clk(clk), .rst(mac_clr), .enable(mac_en),
        .a(mac_a), .b(mac_b), .acc_out(acc_in)
    );

    typedef struct {
        int          len;
        logic [15:0] a;
        logic [15:0] b;
        bit          bubble;
        int          hold;
        logic [15:0] exp_res;
        int          exp_lat;
        int          exp_en;
        int          busy_start;
    } vec_t;

    vec_t vecs[5];
    vec_t after_abort;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int cyc;
        int lat;
        int en_cnt;
        bit seen_busy;
        cyc = 0;
        lat = -1;
        en_cnt = 0;
        seen_busy = 1'b0;
        @(posedge clk); #1;
        start    = 1'b1;
        len      = LEN_W'(v.len);
        op_a     = v.a;
        op_b     = v.b;
        op_valid = v.bubble ? 1'b0 : 1'b1;
        while (lat < 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == v.busy_start);
            if (cyc == v.busy_start) len = LEN_W'(1);
            op_valid = v.bubble ? (cyc % 2 == 1) : 1'b1;
            @(negedge clk);
            if (cyc == 1) check("clear_pulse", {busy, mac_clr, op_ready}, 3'b110);
            if (mac_en) en_cnt++;
            if (res_valid) lat = cyc;
        end
        check("latency", lat, v.exp_lat);
        if (lat < 0) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            return;
        end
        check("result", res_data, v.exp_res);
        check("mac_en_count", en_cnt, v.exp_en);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            op_valid = 1'b0;
            @(negedge clk);
            check("backpressure_hold", {res_valid, mac_en, res_data}, {1'b1, 1'b0, v.exp_res});
        end
        @(posedge clk); #1;
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("release", {res_valid, busy}, 2'b00);
        repeat (3) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        check("stay_idle", seen_busy, 1'b0);
    endtask

    initial begin
        bit seen_valid;
        rst = 1'b1; start = 1'b0; abort = 1'b0; op_valid = 1'b0;
        res_ready = 1'b0; len = '0; op_a = '0; op_b = '0;

        //          len a        b        bub hold exp      lat en busy_start
        vecs[0] = '{3,  FP16_ONE, FP16_ONE, 1'b0, 0, 16'h4200, 7,  3,  0};
        vecs[1] = '{10, 16'h3800, 16'h3800, 1'b1, 5, 16'h4100, 24, 10, 0};
        vecs[2] = '{0,  FP16_ONE, FP16_ONE, 1'b0, 0, FP16_ZERO, 2, 0,  0};
        vecs[3] = '{2,  FP16_ONE, 16'hBC00, 1'b0, 2, 16'hC000, 6,  2,  0};
        vecs[4] = '{3,  FP16_ONE, FP16_ONE, 1'b0, 1, 16'h4200, 7,  3,  2};
        after_abort = '{1, 16'h4000, 16'h4000, 1'b0, 0, 16'h4400, 5, 1, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {op_ready, mac_clr, mac_en, res_valid, busy}, 5'b0);
        check("reset_data", {mac_a, mac_b, res_data}, 48'h0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) run_job(vecs[i]);

        // Abort after two of five handshakes
        @(posedge clk); #1;
        start = 1'b1; len = LEN_W'(5); op_a = FP16_ONE; op_b = FP16_ONE; op_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 abort = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        check("abort_in_run", {busy, op_ready}, 2'b11);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_outputs", {busy, op_ready, mac_en, res_valid, mac_clr}, 5'b00001);
        @(negedge clk);
        check("abort_clr_single", mac_clr, 1'b0);
        seen_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid || busy) seen_valid = 1'b1;
        end
        check("abort_no_result", seen_valid, 1'b0);
        run_job(after_abort);

        // Reset while draining
        @(posedge clk); #1;
        start = 1'b1; len = LEN_W'(2); op_a = FP16_ONE; op_b = FP16_ONE; op_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 op_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("drain_before_rst", {busy, op_ready, mac_a}, {2'b10, FP16_ONE});
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_ctrl", {op_ready, mac_clr, mac_en, res_valid, busy}, 5'b0);
        check("rst_mid_data", {mac_a, mac_b, res_data}, 48'h0);
        @(posedge clk); #1 rst = 1'b0;

        // start together with abort in IDLE must not launch
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start_idle", {busy, mac_clr}, 2'b00);

        run_job(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
